alu4_seq: RTL and testbench
===========================

Name: alu4_seq

Overview:
- Multi-cycle command sequencer that acts as the initiator for the 4-bit ALU.
- Accepts register-level commands over a valid/ready handshake and reads operands from a private 4x4-bit register file.
- Drives the ALU operand/control lines (a, b, clt), samples z and ex, writes the result back and returns a response over a second valid/ready handshake.
- Sits between a test/control front end and the combinational ALU.

Parameters:
- WIDTH, 4, datapath width; must match the ALU's a/b/z width.
- NREG, 4, register count; r0 reads as zero.
- RW, 2, register index width, clog2(NREG).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_ld  in  1  1 = load immediate, 0 = ALU operation.
- cmd_op  in  3  ALU clt code.
- cmd_rd  in  RW  destination register.
- cmd_rs  in  RW  source register for operand a.
- cmd_rt  in  RW  source register for operand b.
- cmd_imm  in  WIDTH  immediate for a load.
- alu_a  out  WIDTH  registered operand a to the ALU.
- alu_b  out  WIDTH  registered operand b to the ALU.
- alu_clt  out  3  registered control to the ALU.
- alu_z  in  WIDTH  ALU result.
- alu_ex  in  1  ALU zero/exception indication.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  result value.
- rsp_zero  out  1  locally computed (rsp_data == 0).
- rsp_ex  out  1  alu_ex sampled with the result.
- rsp_err  out  1  illegal op code.
- dbg_sel  in  RW  debug register select.
- dbg_data  out  WIDTH  combinational read of regfile[dbg_sel].

Behaviour:
- Reset (async, takes effect immediately, including mid-operation):
  - state = IDLE; all registers = 0.
  - alu_a, alu_b, alu_clt = 0.
  - rsp_valid, rsp_data, rsp_zero, rsp_ex, rsp_err = 0.
  - cmd_ready = 1 once reset deasserts.
  - Any in-flight command is dropped, with no write and no response.
- Legal clt codes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed less-than, result 0001 or 0000).
  - 011, 100, 101 are illegal.
- State machine IDLE -> READ -> EXEC -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - A command is accepted on an edge with cmd_valid & cmd_ready; fields are latched.
  - LD: at the accept edge, regfile[rd] <= imm (ignored if rd = 0); rsp_data <= imm; rsp_zero per imm; rsp_ex = 0; rsp_err = 0; go to RESP.
  - Illegal op: no ALU access; rsp_err <= 1; rsp_data <= 0; rsp_zero <= 1; rsp_ex <= 0; go to RESP.
  - Legal op: go to READ.
- READ: on the next edge, alu_a <= reg[rs], alu_b <= reg[rt], alu_clt <= op; go to EXEC.
- EXEC:
  - The ALU settles combinationally during this cycle.
  - On the next edge: rsp_data <= alu_z; rsp_ex <= alu_ex; rsp_zero <= (alu_z == 0); regfile[rd] <= alu_z (unless rd = 0); go to RESP.
- RESP:
  - rsp_valid = 1; all rsp_* fields are held stable until rsp_ready.
  - On an edge with rsp_ready: go to IDLE, rsp_valid = 0.
- Latency:
  - ALU op: rsp_valid rises 3 edges after the accept edge.
  - LD or illegal op: rsp_valid rises 1 edge after the accept edge.
  - Minimum command-to-command spacing is 4 cycles (ALU op) or 2 cycles (LD), with rsp_ready tied high.
- alu_a, alu_b and alu_clt hold their last value outside READ/EXEC.
- Arithmetic is modulo 2^WIDTH and the sequencer adds no carry-out.
- rs = rd or rt = rd: operands are read in READ, before the write in EXEC, so the old value is used.
- r0 always reads 0, through both the datapath and dbg_data.
- cmd_valid asserted outside IDLE: ignored; fields may change freely.
- rsp_ready asserted outside RESP: ignored.

Decomposition:
- Shared package alu4_pkg:
  - clt code constants: CLT_AND = 3'b000, CLT_OR = 3'b001, CLT_ADD = 3'b010, CLT_SUB = 3'b110, CLT_SLT = 3'b111.
  - State enum: IDLE, READ, EXEC, RESP.
  - Function clt_legal().
- One sub-module, alu4_regfile:
  - NREG x WIDTH with async clear and r0 hardwired to zero.
  - Two combinational read ports plus the dbg port; one synchronous write port.
- The FSM and response registers live in alu4_seq.
- The bench connects the existing 4-bit ALU to the alu_* ports.

Test Plan:
- Load then add: LD r1 = 3, LD r2 = 5, ADD rd = 3, rs = 1, rt = 2 -> rsp_data = 1000, rsp_zero = 0; dbg_sel = 3 reads 1000; rsp_valid 3 edges after accept.
- Subtract to zero: LD r1 = 7, SUB rd = 2, rs = 1, rt = 1 -> rsp_data = 0000, rsp_zero = 1, regfile[2] = 0.
- Signed SLT: LD r1 = 1000 (-8), LD r2 = 0011 (3), SLT r3, r1, r2 -> 0001; swapping the operands -> 0000.
- Illegal op and r0 write: op = 100 -> rsp_err = 1, no register changes, rsp_valid 1 edge after accept. LD r0 = F -> dbg r0 = 0.
- Response backpressure: hold rsp_ready = 0 for 5 cycles after an AND of r1 = 1100, r2 = 1010 -> rsp_data stays 1000, cmd_ready stays 0, a new cmd_valid is ignored; releasing rsp_ready returns to IDLE.
- Reset mid-operation: assert reset during EXEC -> outputs and regs go to 0 immediately, no response is issued, and cmd_ready = 1 on the first cycle after deassert.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU command sequencer: ALU control codes,
// sequencer state encoding and the op-code legality check.
package alu4_pkg;

  localparam logic [2:0] CLT_AND = 3'b000;
  localparam logic [2:0] CLT_OR  = 3'b001;
  localparam logic [2:0] CLT_ADD = 3'b010;
  localparam logic [2:0] CLT_SUB = 3'b110;
  localparam logic [2:0] CLT_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  // True for the five codes the ALU implements; 011/100/101 never reach it.
  function automatic logic clt_legal(input logic [2:0] op);
    case (op)
      CLT_AND, CLT_OR, CLT_ADD, CLT_SUB, CLT_SLT: return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu4_regfile.sv
// Private register file for the sequencer: NREG x WIDTH, async clear,
// r0 hardwired to zero, two operand read ports, one debug read port and a
// single synchronous write port.
module alu4_regfile #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int RW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [RW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [RW-1:0]    ra0,
  input  logic [RW-1:0]    ra1,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] dbg_data
);

  logic [NREG-1:0][WIDTH-1:0] regs;

  // Write port; writes to r0 are dropped so the entry stays at its cleared value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Read ports force r0 to zero independently of the storage contents.
  assign rd0      = (ra0     == '0) ? '0 : regs[ra0];
  assign rd1      = (ra1     == '0) ? '0 : regs[ra1];
  assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/alu4_seq.sv
// Multi-cycle command sequencer driving a combinational 4-bit ALU.
// IDLE accepts a command; LD and illegal ops answer straight from IDLE,
// legal ALU ops go READ (register operands) -> EXEC (sample ALU, write back)
// -> RESP, where the response is held until the consumer takes it.
module alu4_seq
  import alu4_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 4,
  parameter int RW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic [2:0]       cmd_op,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [RW-1:0]    cmd_rs,
  input  logic [RW-1:0]    cmd_rt,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_clt,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_ex,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_ex,
  output logic             rsp_err,
  input  logic [RW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [RW-1:0]    rd_q, rs_q, rt_q;
  logic             accept;
  logic             cmd_legal;
  logic             rf_we;
  logic [RW-1:0]    rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic [WIDTH-1:0] rf_rd0, rf_rd1;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign cmd_legal = clt_legal(cmd_op);

  // One write port shared by LD (at the accept edge, from the command bus)
  // and ALU write-back (at the EXEC edge, from the latched destination).
  assign rf_we = (accept && cmd_ld) || (state_q == EXEC);
  assign rf_wa = (state_q == EXEC) ? rd_q  : cmd_rd;
  assign rf_wd = (state_q == EXEC) ? alu_z : cmd_imm;

  alu4_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .RW    (RW)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .wa       (rf_wa),
    .wd       (rf_wd),
    .ra0      (rs_q),
    .ra1      (rt_q),
    .dbg_sel  (dbg_sel),
    .rd0      (rf_rd0),
    .rd1      (rf_rd1),
    .dbg_data (dbg_data)
  );

  // State register; reset drops any in-flight command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_ld || !cmd_legal) ? RESP : READ;
      end
      READ: state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, ALU operand registers and response registers. Operands are
  // read in READ, so a destination that aliases a source sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_clt  <= '0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_ex   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            rd_q <= cmd_rd;
            rs_q <= cmd_rs;
            rt_q <= cmd_rt;
            if (cmd_ld) begin
              rsp_data <= cmd_imm;
              rsp_zero <= (cmd_imm == '0);
              rsp_ex   <= 1'b0;
              rsp_err  <= 1'b0;
            end else if (!cmd_legal) begin
              rsp_data <= '0;
              rsp_zero <= 1'b1;
              rsp_ex   <= 1'b0;
              rsp_err  <= 1'b1;
            end
          end
        end
        READ: begin
          alu_a   <= rf_rd0;
          alu_b   <= rf_rd1;
          alu_clt <= op_q;
        end
        EXEC: begin
          rsp_data <= alu_z;
          rsp_ex   <= alu_ex;
          rsp_zero <= (alu_z == '0);
          rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_seq.sv
// Scoreboard bench for alu4_seq: a behavioural ALU hangs off the alu_* ports,
// the driver pushes expected responses computed from an integer register
// model, and an independent monitor pops and compares on each response.
module tb_alu4_seq;
  import alu4_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_ld = 1'b0;
  logic [2:0] cmd_op = '0, alu_clt;
  logic [1:0] cmd_rd = '0, cmd_rs = '0, cmd_rt = '0, dbg_sel = '0;
  logic [3:0] cmd_imm = '0, alu_a, alu_b, alu_z, rsp_data, dbg_data;
  logic       alu_ex, rsp_valid, rsp_ready = 1'b1, rsp_zero, rsp_ex, rsp_err;

  alu4_seq #(.WIDTH(4), .NREG(4), .RW(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_clt(alu_clt), .alu_z(alu_z), .alu_ex(alu_ex),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_ex(rsp_ex), .rsp_err(rsp_err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 4-bit ALU: ex flags a zero result.
  function automatic logic [3:0] bench_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    case (op)
      CLT_AND: return a & b;
      CLT_OR:  return a | b;
      CLT_ADD: return a + b;
      CLT_SUB: return a - b;
      CLT_SLT: return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction
  assign alu_z  = bench_alu(alu_a, alu_b, alu_clt);
  assign alu_ex = (alu_z == 4'd0);

  // Reference arithmetic on plain integers.
  function automatic int model_op(input int a, input int b, input int op);
    int sa, sb;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    case (op)
      0: return a & b;
      1: return a | b;
      2: return (a + b) % 16;
      6: return (a - b + 16) % 16;
      7: return (sa < sb) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    int data; int zero; int ex; int err; int lat; int acc;
  } exp_t;

  exp_t q[$];
  int   model_rf[4];
  int   checks = 0, failures = 0;
  bit   rr_rand = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one command at the first IDLE cycle; the model is updated at issue
  // because the sequencer serialises commands.
  task automatic issue(input bit ld, input int op, input int rd, input int rs,
                       input int rt, input int imm);
    exp_t e;
    bit   got = 1'b0;
    int   r;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    if (!got) begin chk("cmd_ready_timeout", 0, 1); return; end
    cmd_valid = 1'b1; cmd_ld = ld; cmd_op = 3'(op);
    cmd_rd = 2'(rd); cmd_rs = 2'(rs); cmd_rt = 2'(rt); cmd_imm = 4'(imm);
    e.acc = cyc;
    if (ld) begin
      e.data = imm; e.zero = (imm == 0); e.ex = 0; e.err = 0; e.lat = 1;
      if (rd != 0) model_rf[rd] = imm;
    end else if (op == 0 || op == 1 || op == 2 || op == 6 || op == 7) begin
      r = model_op(model_rf[rs], model_rf[rt], op);
      e.data = r; e.zero = (r == 0); e.ex = (r == 0); e.err = 0; e.lat = 3;
      if (rd != 0) model_rf[rd] = r;
    end else begin
      e.data = 0; e.zero = 1; e.ex = 0; e.err = 1; e.lat = 1;
    end
    q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_ld = 1'($urandom); cmd_op = 3'($urandom); cmd_imm = 4'($urandom);
    cmd_rd = 2'($urandom); cmd_rs = 2'($urandom); cmd_rt = 2'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && cmd_ready && !rsp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_dbg(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      chk($sformatf("%s_dbg_r%0d", tag, i), dbg_data, model_rf[i]);
    end
  endtask

  // Response randomiser, changed just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rr_rand) rsp_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: compare each new response, then require it held until taken.
  bit   pv = 1'b0, pr = 1'b0, have = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0; pr = 1'b0; have = 1'b0;
    end else begin
      if (pv && pr) begin
        chk("rsp_drop_after_take", rsp_valid, 0);
      end else if (pv) begin
        chk("rsp_hold_valid", rsp_valid, 1);
        if (have) begin
          chk("rsp_hold_data", rsp_data, cur.data);
          chk("rsp_hold_err", rsp_err, cur.err);
        end
      end else if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
          have = 1'b0;
        end else begin
          cur = q.pop_front();
          have = 1'b1;
          chk("rsp_data", rsp_data, cur.data);
          chk("rsp_zero", rsp_zero, cur.zero);
          chk("rsp_ex", rsp_ex, cur.ex);
          chk("rsp_err", rsp_err, cur.err);
          chk("rsp_latency", cyc - cur.acc, cur.lat);
        end
      end
      pv = rsp_valid;
      pr = rsp_ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 4; i++) model_rf[i] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_alu_clt", alu_clt, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk_dbg("rst");

    // Load then add.
    issue(1, 0, 1, 0, 0, 3);
    issue(1, 0, 2, 0, 0, 5);
    issue(0, 2, 3, 1, 2, 0);
    wait_idle();
    chk_dbg("add");

    // Subtract to zero.
    issue(1, 0, 1, 0, 0, 7);
    issue(0, 6, 2, 1, 1, 0);
    wait_idle();
    chk_dbg("sub");

    // Signed SLT both ways.
    issue(1, 0, 1, 0, 0, 8);
    issue(1, 0, 2, 0, 0, 3);
    issue(0, 7, 3, 1, 2, 0);
    issue(0, 7, 3, 2, 1, 0);
    wait_idle();
    chk_dbg("slt");

    // Illegal op and r0 write; alias rd=rs uses old operand.
    issue(0, 4, 1, 2, 3, 0);
    issue(1, 0, 0, 0, 0, 15);
    issue(0, 2, 2, 2, 2, 0);
    wait_idle();
    chk_dbg("illegal");

    // Response backpressure with a competing command.
    issue(1, 0, 1, 0, 0, 12);
    issue(1, 0, 2, 0, 0, 10);
    wait_idle();
    rsp_ready = 1'b0;
    issue(0, 0, 3, 1, 2, 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    chk("bp_rsp_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_rd = 2'd3; cmd_imm = 4'hF;
      @(negedge clk);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_data", rsp_data, 8);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    chk_dbg("bp");

    // Reset during EXEC.
    issue(0, 2, 3, 1, 2, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) model_rf[i] = 0;
    q.delete();
    chk("mid_alu_a", alu_a, 0);
    chk("mid_alu_b", alu_b, 0);
    chk("mid_alu_clt", alu_clt, 0);
    chk("mid_rsp_data", rsp_data, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk_dbg("mid");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_cmd_ready", cmd_ready, 1);
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 0);
    end

    // Randomised traffic with random backpressure.
    rr_rand = 1'b1;
    for (int n = 0; n < 120; n++) begin
      issue($urandom_range(0, 9) < 3, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
    end
    wait_idle();
    rr_rand = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    wait_idle();
    chk_dbg("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
